phase_cycle_scheduler: RTL and testbench
========================================

// Module: phase_cycle_scheduler
// PURPOSE
//   Programmable multi-phase cycle sequencer. On a start request it steps through
//   NPHASE phases, each lasting a software-loaded number of clk cycles, then raises
//   a sticky done flag. It sits beside the datapath and publishes the current phase
//   index, so downstream logic can gate its operations per phase.
// PARAMETERS
//   PW       2   phase-index width; NPHASE = 2**PW phases (default 4)
//   CW       5   phase-length / counter width in bits (lengths 0..2**CW-1)
//   DEF_LEN  10  reset value loaded into every phase-length register
// PORTS
//   clk        in   1   clock; all logic on posedge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   run request, level-sampled each cycle
//   abort      in   1   cancel a run in progress
//   cfg_we     in   1   phase-length write strobe
//   cfg_idx    in   PW  phase index for the write
//   cfg_len    in   CW  phase length in cycles for the write
//   busy       out  1   high while a run is in progress (state RUN)
//   phase      out  PW  current phase index; 0 when not in RUN
//   phase_stb  out  1   one-cycle pulse on the first cycle of every phase
//   done       out  1   sticky completion flag
//   cfg_err    out  1   one-cycle pulse: a write was rejected
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, phase=0, phase_stb=0, done=0, cfg_err=0,
//     cnt=0, len[0..NPHASE-1]=DEF_LEN. Reset overrides every other input.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE->RUN    when start=1 and abort=0.
//     RUN->RUN     cnt increments. When cnt==eff_len-1 the counter clears and the
//                  FSM advances to the next phase.
//     RUN->DONE    when the last cycle of phase NPHASE-1 ends.
//     RUN->IDLE    when abort=1. The run ends immediately and done stays 0.
//     DONE->RUN    when start=1 and abort=0. done clears on the same edge.
//     DONE->IDLE   when abort=1. done clears.
//   - Latency: start sampled high at edge N gives busy=1, phase=0 and
//     phase_stb=1 at edge N+1.
//   - Phase duration: phase k lasts eff_len[k] = (len[k]==0) ? 1 : len[k] cycles.
//     A zero length is never skipped.
//   - Run end: done=1 and busy=0 one cycle after the last cycle of phase NPHASE-1.
//     Total busy time is the sum of eff_len over all phases.
//   - phase_stb pulses once on entry to each phase, including phase 0.
//   - While in RUN, start is ignored; a run is never restarted mid-flight.
//   - start and abort in the same cycle: abort wins in every state.
//   - Config writes: cfg_we in IDLE or DONE writes len[cfg_idx]=cfg_len on that edge.
//     cfg_we in RUN is dropped: len is unchanged and cfg_err=1 for one cycle.
//   - Counter: cnt is CW bits and compares only against eff_len-1, so it never
//     wraps inside a phase.
// CONFIGURATION
//   CYCLE_SCHED_LOOP_EN defined:
//     - Adds input port loop (1 bit).
//     - If loop=1 at the last cycle of phase NPHASE-1, the FSM wraps to phase 0
//       instead of entering DONE. busy stays 1 and phase_stb pulses.
//     - abort still exits to IDLE.
//   CYCLE_SCHED_LOOP_EN undefined:
//     - No loop port; behaviour is exactly loop=0.
// TESTING
//   1. Reset, then start=1 for one cycle with default lengths -> busy high
//      for 40 cycles; phase_stb at offsets 0, 10, 20, 30; done=1 on cycle 41.
//   2. Write len={3,1,0,2}, then start -> phases last 3,1,1,2 cycles; busy
//      high for 7 cycles; phase_stb on 4 consecutive phase entries; done after.
//   3. Start, then abort in the 2nd cycle of phase 2 -> busy=0, phase=0 and
//      done=0 next cycle; a later start runs from phase 0.
//   4. cfg_we with idx=1, len=7 during RUN -> one-cycle cfg_err pulse;
//      len[1] is unchanged, verified by phase 1 duration on the next run.
//   5. rst=1 mid-run in phase 1 -> all outputs at reset values next cycle;
//      len registers back to DEF_LEN.
//   6. In DONE, assert start and abort together -> IDLE, done=0, busy stays 0.
//      With CYCLE_SCHED_LOOP_EN and loop=1: phase wraps 3->0, done never
//      asserts.

Source files
------------

// File: rtl/phase_cycle_scheduler.sv
// Programmable multi-phase cycle sequencer: steps through 2**PW phases of loadable length.
// Optional macro CYCLE_SCHED_LOOP_EN adds a loop input that wraps the last phase back to phase 0.
module phase_cycle_scheduler #(
    parameter int PW      = 2,
    parameter int CW      = 5,
    parameter int DEF_LEN = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_idx,
    input  logic [CW-1:0] cfg_len,
`ifdef CYCLE_SCHED_LOOP_EN
    input  logic          loop,
`endif
    output logic          busy,
    output logic [PW-1:0] phase,
    output logic          phase_stb,
    output logic          done,
    output logic          cfg_err
);

    localparam int NPHASE = 2 ** PW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len [NPHASE];

    logic [CW-1:0] cur_len;
    logic [CW-1:0] last_cnt;
    logic          phase_end;
    logic          last_phase;
    logic          wrap;

`ifdef CYCLE_SCHED_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    // A zero length behaves as one cycle, so the terminal count is never below zero.
    always_comb begin
        cur_len    = len[phase];
        last_cnt   = (cur_len == '0) ? '0 : cur_len - 1'b1;
        phase_end  = (cnt == last_cnt);
        last_phase = (phase == PW'(NPHASE - 1));
    end

    assign busy = (state == S_RUN);

    // NOTE: every register here, the length table included, is written with <= so all
    // updates of one edge see the pre-edge values; the table is reset because its
    // power-up contents (DEF_LEN) are architecturally visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= '0;
            phase_stb <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < NPHASE; i++) begin
                len[i] <= CW'(DEF_LEN);
            end
        end else begin
            phase_stb <= 1'b0;
            cfg_err   <= 1'b0;

            if (cfg_we) begin
                if (state == S_RUN) begin
                    cfg_err <= 1'b1;
                end else begin
                    len[cfg_idx] <= cfg_len;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state     <= S_RUN;
                        done      <= 1'b0;
                        cnt       <= '0;
                        phase     <= '0;
                        phase_stb <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        phase <= '0;
                    end else if (phase_end) begin
                        cnt <= '0;
                        if (!last_phase) begin
                            phase     <= phase + 1'b1;
                            phase_stb <= 1'b1;
                        end else if (wrap) begin
                            phase     <= '0;
                            phase_stb <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            phase <= '0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    phase <= '0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_cycle_scheduler.sv
// Directed bench for phase_cycle_scheduler; inputs driven and outputs sampled on negedge.
// Define CYCLE_SCHED_LOOP_EN to also exercise the loop wrap.
module tb_phase_cycle_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [4:0] cfg_len;
`ifdef CYCLE_SCHED_LOOP_EN
    logic       loop;
`endif
    logic       busy;
    logic [1:0] phase;
    logic       phase_stb;
    logic       done;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;

    phase_cycle_scheduler #(.PW(2), .CW(5), .DEF_LEN(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_len   (cfg_len),
`ifdef CYCLE_SCHED_LOOP_EN
        .loop      (loop),
`endif
        .busy      (busy),
        .phase     (phase),
        .phase_stb (phase_stb),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".phase"}, phase, 2'd0);
        check({tag, ".stb"}, phase_stb, 1'b0);
        check({tag, ".done"}, done, exp_done);
    endtask

    task automatic write_len(input logic [1:0] idx, input logic [4:0] val);
        cfg_we = 1'b1; cfg_idx = idx; cfg_len = val;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_idle_write", cfg_err, 1'b0);
    endtask

    // Leaves the bench at the negedge of the first busy cycle.
    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ev_kind: 0 none, 1 abort at ev_at, 2 rst at ev_at, 3 cfg write during RUN at ev_at.
    task automatic check_run(input int l0, l1, l2, l3, input int ev_kind, input int ev_at);
        int lens [4];
        int idx;
        lens = '{l0, l1, l2, l3};
        idx  = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < lens[k]; c++) begin
                check("run.busy", busy, 1'b1);
                check("run.phase", phase, k[1:0]);
                check("run.stb", phase_stb, (c == 0));
                check("run.done", done, 1'b0);
                check("run.cfg_err", cfg_err, (ev_kind == 3 && idx == ev_at + 1));
                if (ev_kind == 3 && idx == ev_at) begin
                    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_len = 5'd7;
                end else begin
                    cfg_we = 1'b0;
                end
                if ((ev_kind == 1 || ev_kind == 2) && idx == ev_at) begin
                    if (ev_kind == 1) abort = 1'b1;
                    else rst = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    rst   = 1'b0;
                    check_idle(ev_kind == 1 ? "abort" : "midrun_rst", 1'b0);
                    check("after_event.cfg_err", cfg_err, 1'b0);
                    return;
                end
                idx++;
                @(negedge clk);
            end
        end
        cfg_we = 1'b0;
        check_idle("run_end", 1'b1);
        check("run_end.cfg_err", cfg_err, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_len = 5'd3;
`ifdef CYCLE_SCHED_LOOP_EN
        loop = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; cfg_we = 1'b0;
        check_idle("reset", 1'b0);
        check("reset.cfg_err", cfg_err, 1'b0);

        // Default lengths: 40 busy cycles, done on the 41st.
        start_run();
        check_run(10, 10, 10, 10, 0, 0);

        // Writes accepted in DONE; zero length lasts one cycle.
        write_len(2'd0, 5'd3);
        write_len(2'd1, 5'd1);
        write_len(2'd2, 5'd0);
        write_len(2'd3, 5'd2);
        check("done_after_writes", done, 1'b1);
        start_run();
        check_run(3, 1, 1, 2, 0, 0);

        // Abort on the 2nd cycle of phase 2, then a fresh run from phase 0.
        write_len(2'd2, 5'd4);
        start_run();
        check_run(3, 1, 4, 2, 1, 5);
        @(negedge clk);
        check_idle("abort_hold", 1'b0);

        // Write during RUN is rejected; the following run shows len[1] still 1.
        start_run();
        check_run(3, 1, 4, 2, 3, 2);
        start_run();
        check_run(3, 1, 4, 2, 0, 0);

        // Synchronous reset in phase 1 restores default lengths.
        start_run();
        check_run(3, 1, 4, 2, 2, 3);
        start_run();
        check_run(10, 10, 10, 10, 0, 0);

        // start with abort in DONE and in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check_idle("done_start_abort", 1'b0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_idle("idle_start_abort", 1'b0);
        @(negedge clk);
        check_idle("idle_hold", 1'b0);

`ifdef CYCLE_SCHED_LOOP_EN
        write_len(2'd0, 5'd1);
        write_len(2'd1, 5'd2);
        write_len(2'd2, 5'd1);
        write_len(2'd3, 5'd1);
        loop = 1'b1;
        start_run();
        for (int lap = 0; lap < 2; lap++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < ((k == 1) ? 2 : 1); c++) begin
                    check("loop.busy", busy, 1'b1);
                    check("loop.phase", phase, k[1:0]);
                    check("loop.stb", phase_stb, (c == 0));
                    check("loop.done", done, 1'b0);
                    @(negedge clk);
                end
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; loop = 1'b0;
        check_idle("loop_abort", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
